// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and sizing helpers for the systolic multiply controller.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      STREAM = 3'd2,
      FLUSH  = 3'd3,
      DRAIN  = 3'd4,
      DONE   = 3'd5
   } ctrl_state_e;

   // Cycles for the last operand wavefront to cross an N x N array.
   function automatic int flush_cycles(input int n);
      return 2 * n - 1;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // One extra bit over the largest count so terminal compares never wrap.
   function automatic int cnt_width(input int timeout, input int n, input int drain_lat);
      return $clog2(max3(timeout, 2 * n, drain_lat)) + 1;
   endfunction

   function automatic int col_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/systolic_mult_controller_if.sv
// systolic_mult_controller_if: host/array-side bus of the multiply controller.
// master = host/array side (drives start, status and east lanes), slave = controller.
interface systolic_mult_controller_if #(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32
) ();
   localparam int COL_W = systolic_pkg::col_width(N);

   logic                    start_i;
   logic                    queues_empty_i;
   logic                    acc_valid_all_i;
   logic [N*DATA_WIDTH-1:0] east_i;
   logic                    array_start_o;
   logic [N-1:0]            sel_acc_o;
   logic [N*DATA_WIDTH-1:0] result_o;
   logic                    result_valid_o;
   logic [COL_W-1:0]        result_col_o;
   logic                    busy_o;
   logic                    done_o;
   logic                    error_o;

   modport master (
      output start_i, queues_empty_i, acc_valid_all_i, east_i,
      input  array_start_o, sel_acc_o, result_o, result_valid_o, result_col_o,
             busy_o, done_o, error_o
   );

   modport slave (
      input  start_i, queues_empty_i, acc_valid_all_i, east_i,
      output array_start_o, sel_acc_o, result_o, result_valid_o, result_col_o,
             busy_o, done_o, error_o
   );
endinterface

// File: rtl/systolic_mult_controller.sv
// systolic_mult_controller: launches the input queues, waits for them to drain and for
// the wavefront to flush, then unloads the accumulators one column at a time.
// Every output is a flop whose next value is derived from the next state.
module systolic_mult_controller
   import systolic_pkg::*;
#(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DRAIN_LAT  = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   systolic_mult_controller_if.slave bus
);
   localparam int LANES_W = N * DATA_WIDTH;
   localparam int CNT_W   = cnt_width(TIMEOUT, N, DRAIN_LAT);
   localparam int COL_W   = col_width(N);

   localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(flush_cycles(N) - 1);
   localparam logic [CNT_W-1:0] LAT_LAST    = CNT_W'(DRAIN_LAT - 1);
   localparam logic [COL_W-1:0] COL_LAST    = COL_W'(N - 1);

   ctrl_state_e         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;          // stream wait / flush countdown / drain hold
   logic [COL_W-1:0]    col_q, col_d;
   logic                first_q, first_d;      // first STREAM cycle, empty flag not trusted yet
   logic                array_start_q, array_start_d;
   logic [N-1:0]        sel_acc_q, sel_acc_d;
   logic [LANES_W-1:0]  result_q, result_d;
   logic                result_valid_q, result_valid_d;
   logic [COL_W-1:0]    result_col_q, result_col_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;

   // State, counters and registered outputs; reset aborts any run in progress.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         col_q          <= '0;
         first_q        <= 1'b0;
         array_start_q  <= 1'b0;
         sel_acc_q      <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         result_col_q   <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         col_q          <= col_d;
         first_q        <= first_d;
         array_start_q  <= array_start_d;
         sel_acc_q      <= sel_acc_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         result_col_q   <= result_col_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         error_q        <= error_d;
      end
   end

   // Next-state sequencing plus the next value of every registered output.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      col_d          = col_q;
      first_d        = first_q;
      result_d       = result_q;
      result_col_d   = result_col_q;
      result_valid_d = 1'b0;
      error_d        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start_i) state_d = LAUNCH;
         end
         LAUNCH: begin
            state_d = STREAM;
            cnt_d   = '0;
            first_d = 1'b1;
         end
         STREAM: begin
            if (first_q) begin
               first_d = 1'b0;
            end else if (bus.queues_empty_i) begin
               // Empty takes priority over a coincident timeout.
               state_d = FLUSH;
               cnt_d   = FLUSH_LOAD;
            end else if (cnt_q == STREAM_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FLUSH: begin
            // Countdown saturates at zero; then wait as long as the accumulators need.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (bus.acc_valid_all_i) begin
               state_d = DRAIN;
               col_d   = '0;
            end
         end
         DRAIN: begin
            if (cnt_q == LAT_LAST) begin
               result_d       = bus.east_i;
               result_valid_d = 1'b1;
               result_col_d   = col_q;
               cnt_d          = '0;
               if (col_q == COL_LAST) state_d = DONE;
               else                   col_d   = col_q + COL_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            col_d   = '0;
         end
         default: state_d = IDLE;
      endcase

      array_start_d = (state_d == LAUNCH);
      busy_d        = (state_d != IDLE);
      done_d        = (state_d == DONE);
      sel_acc_d     = '0;
      if (state_d == DRAIN) sel_acc_d[col_d] = 1'b1;
   end

   assign bus.array_start_o  = array_start_q;
   assign bus.sel_acc_o      = sel_acc_q;
   assign bus.result_o       = result_q;
   assign bus.result_valid_o = result_valid_q;
   assign bus.result_col_o   = result_col_q;
   assign bus.busy_o         = busy_q;
   assign bus.done_o         = done_q;
   assign bus.error_o        = error_q;

endmodule

// File: tb/tb_systolic_mult_controller.sv
// tb_systolic_mult_controller: directed scenarios with hand-derived cycle numbers plus
// randomized runs checked against an event-level reference model.
module tb_systolic_mult_controller;
   localparam int N    = 4;
   localparam int DW   = 32;
   localparam int DL   = 2;
   localparam int TO   = 16;
   localparam int FC   = 2 * N - 1;
   localparam int LW   = N * DW;
   localparam int CW   = N + 5;
   localparam int MAXC = 256;

   logic clk   = 1'b0;
   logic rst_i = 1'b1;

   systolic_mult_controller_if #(.N(N), .DATA_WIDTH(DW)) bus ();

   systolic_mult_controller #(
      .N(N), .DATA_WIDTH(DW), .DRAIN_LAT(DL), .TIMEOUT(TO)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // per-cycle stimulus
   bit          st  [MAXC];
   bit          emp [MAXC];
   bit          acc [MAXC];
   logic [LW-1:0] east [MAXC];
   int          reset_at;

   // per-cycle observations
   logic          r_as [MAXC];
   logic [N-1:0]  r_sel [MAXC];
   logic [LW-1:0] r_res [MAXC];
   logic          r_rv [MAXC];
   logic [1:0]    r_col [MAXC];
   logic          r_busy [MAXC];
   logic          r_done [MAXC];
   logic          r_err [MAXC];

   // reference-model expectations
   logic          e_as [MAXC];
   logic [N-1:0]  e_sel [MAXC];
   logic [LW-1:0] e_res [MAXC];
   logic          e_rv [MAXC];
   logic [1:0]    e_col [MAXC];
   logic [1:0]    e_rvcol [MAXC];
   logic [LW-1:0] e_rvval [MAXC];
   logic          e_busy [MAXC];
   logic          e_done [MAXC];
   logic          e_err [MAXC];

   task automatic clear_stim();
      for (int k = 0; k < MAXC; k++) begin
         st[k]   = 1'b0;
         emp[k]  = 1'b0;
         acc[k]  = 1'b1;
         east[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      reset_at = -1;
   endtask

   // Cycle 0 starts right after the reset-release edge; inputs change 1 ns after
   // each rising edge and outputs are sampled 2 ns after it.
   task automatic run_scenario(input int ncyc);
      rst_i = 1'b1;
      bus.start_i = 1'b0;
      bus.queues_empty_i = 1'b0;
      bus.acc_valid_all_i = 1'b0;
      bus.east_i = '0;
      repeat (2) @(posedge clk);
      for (int k = 0; k < ncyc; k++) begin
         if (k > 0) @(posedge clk);
         #1;
         rst_i               = (k == reset_at);
         bus.start_i         = st[k];
         bus.queues_empty_i  = emp[k];
         bus.acc_valid_all_i = acc[k];
         bus.east_i          = east[k];
         #1;
         r_as[k]   = bus.array_start_o;
         r_sel[k]  = bus.sel_acc_o;
         r_res[k]  = bus.result_o;
         r_rv[k]   = bus.result_valid_o;
         r_col[k]  = bus.result_col_o;
         r_busy[k] = bus.busy_o;
         r_done[k] = bus.done_o;
         r_err[k]  = bus.error_o;
      end
      rst_i = 1'b0;
      bus.start_i = 1'b0;
   endtask

   function automatic logic [CW-1:0] obs_ctl(input int k);
      return {r_as[k], r_busy[k], r_sel[k], r_rv[k], r_done[k], r_err[k]};
   endfunction

   function automatic logic [CW-1:0] mdl_ctl(input int k);
      return {e_as[k], e_busy[k], e_sel[k], e_rv[k], e_done[k], e_err[k]};
   endfunction

   // Control outputs of one successful run: start accepted at t0, drain begins at d.
   function automatic logic [CW-1:0] spec_ctl(input int k, input int t0, input int d);
      logic as_b, busy_b, rv_b, done_b;
      logic [N-1:0] sel_v;
      int last;
      last   = d + N * DL;
      as_b   = (k == t0 + 1);
      busy_b = (k >= t0 + 1) && (k <= last);
      sel_v  = '0;
      if (k >= d && k < last) sel_v = N'(1) << ((k - d) / DL);
      rv_b   = (k > d) && (k <= last) && (((k - d) % DL) == 0);
      done_b = (k == last);
      return {as_b, busy_b, sel_v, rv_b, done_b, 1'b0};
   endfunction

   // Event-level model: walk accepted starts, locate the empty/acc-valid events in
   // the stimulus and place every output pulse from the documented latencies.
   task automatic build_expected(input int ncyc);
      int idle_from, lim, e, x, d, last, c;
      logic [LW-1:0] cur;
      logic [1:0] cur_col;
      for (int k = 0; k < MAXC; k++) begin
         e_as[k] = 0; e_sel[k] = '0; e_rv[k] = 0; e_rvcol[k] = '0; e_rvval[k] = '0;
         e_busy[k] = 0; e_done[k] = 0; e_err[k] = 0;
      end
      idle_from = 0;
      for (int t = 0; t < ncyc; t++) begin
         if (!st[t] || t < idle_from || t == reset_at) continue;
         lim = (reset_at > t && reset_at < ncyc) ? reset_at : ncyc;
         e = -1;
         for (int s = t + 3; s <= t + 2 + TO; s++) begin
            if (emp[s]) begin e = s; break; end
         end
         if (t + 1 < lim) e_as[t+1] = 1;
         if (e < 0) begin
            last = t + 3 + TO;
            for (c = t + 1; c < last; c++) if (c < lim) e_busy[c] = 1;
            if (last < lim) e_err[last] = 1;
            idle_from = last;
         end else begin
            x = e + FC;
            while (x < MAXC && !acc[x]) x++;
            d = x + 1;
            last = d + N * DL;
            for (c = t + 1; c <= last; c++) if (c < lim) e_busy[c] = 1;
            for (int col = 0; col < N; col++) begin
               for (int j = 0; j < DL; j++) begin
                  c = d + col * DL + j;
                  if (c < lim) e_sel[c][col] = 1'b1;
               end
               c = d + (col + 1) * DL;
               if (c < lim) begin
                  e_rv[c] = 1;
                  e_rvcol[c] = 2'(col);
                  e_rvval[c] = east[c-1];
               end
            end
            if (last < lim) e_done[last] = 1;
            idle_from = last + 1;
         end
         if (reset_at > t && reset_at <= last) idle_from = reset_at + 1;
      end
      cur = '0;
      cur_col = '0;
      for (int k = 0; k < ncyc; k++) begin
         if (k == reset_at) begin cur = '0; cur_col = '0; end
         if (e_rv[k]) begin cur = e_rvval[k]; cur_col = e_rvcol[k]; end
         e_res[k] = cur;
         e_col[k] = cur_col;
      end
   endtask

   task automatic test_reset();
      logic [LW+N+7:0] all_out;
      rst_i = 1'b1;
      bus.start_i = 1'b1;
      bus.queues_empty_i = 1'b1;
      bus.acc_valid_all_i = 1'b1;
      bus.east_i = '1;
      repeat (3) @(posedge clk);
      #1;
      all_out = {bus.array_start_o, bus.sel_acc_o, bus.result_o, bus.result_valid_o,
                 bus.result_col_o, bus.busy_o, bus.done_o, bus.error_o};
      n_vec++;
      if (all_out !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      $display("scenario reset: outputs held at zero");
   endtask

   task automatic test_nominal();
      logic [CW-1:0] exp_c;
      clear_stim();
      st[0] = 1'b1;
      for (int k = 10; k < MAXC; k++) emp[k] = 1'b1;
      run_scenario(36);
      for (int k = 0; k < 36; k++) begin
         exp_c = spec_ctl(k, 0, 18);
         n_vec++;
         if (obs_ctl(k) !== exp_c) begin
            n_err++;
            $display("FAIL nominal_ctl cycle %0d: got %b expected %b", k, obs_ctl(k), exp_c);
         end
         if (exp_c[2]) begin
            n_vec++;
            if (r_res[k] !== east[k-1] || r_col[k] !== 2'((k - 18) / DL - 1)) begin
               n_err++;
               $display("FAIL nominal_result cycle %0d: got col %0d data %h expected col %0d data %h",
                        k, r_col[k], r_res[k], (k - 18) / DL - 1, east[k-1]);
            end
         end
      end
      $display("scenario nominal: start @0, done expected @26");
   endtask

   task automatic test_timeout();
      logic [CW-1:0] exp_c;
      clear_stim();
      st[0] = 1'b1;
      run_scenario(30);
      for (int k = 0; k < 30; k++) begin
         exp_c = {(k == 1), (k >= 1 && k <= 18), {N{1'b0}}, 1'b0, 1'b0, (k == 19)};
         n_vec++;
         if (obs_ctl(k) !== exp_c) begin
            n_err++;
            $display("FAIL timeout_ctl cycle %0d: got %b expected %b", k, obs_ctl(k), exp_c);
         end
      end
      $display("scenario timeout: error expected @19");
   endtask

   task automatic test_flush_stall();
      logic [CW-1:0] exp_c;
      clear_stim();
      st[0] = 1'b1;
      for (int k = 10; k < MAXC; k++) emp[k] = 1'b1;
      for (int k = 0; k < 22; k++) acc[k] = 1'b0;
      run_scenario(40);
      for (int k = 0; k < 40; k++) begin
         exp_c = spec_ctl(k, 0, 23);
         n_vec++;
         if (obs_ctl(k) !== exp_c) begin
            n_err++;
            $display("FAIL flush_stall_ctl cycle %0d: got %b expected %b", k, obs_ctl(k), exp_c);
         end
      end
      $display("scenario flush stall: drain expected @23, done @31");
   endtask

   task automatic test_start_ignored();
      logic [CW-1:0] exp_c;
      clear_stim();
      st[0] = 1'b1; st[5] = 1'b1; st[26] = 1'b1; st[27] = 1'b1;
      for (int k = 10; k < MAXC; k++) emp[k] = 1'b1;
      run_scenario(52);
      for (int k = 0; k < 52; k++) begin
         exp_c = spec_ctl(k, 0, 18) | spec_ctl(k, 27, 38);
         n_vec++;
         if (obs_ctl(k) !== exp_c) begin
            n_err++;
            $display("FAIL start_ignored_ctl cycle %0d: got %b expected %b", k, obs_ctl(k), exp_c);
         end
      end
      $display("scenario start ignored: done @26, relaunch @28");
   endtask

   task automatic test_mid_reset();
      logic [CW-1:0] exp_c;
      clear_stim();
      st[0] = 1'b1; st[24] = 1'b1;
      for (int k = 10; k < MAXC; k++) emp[k] = 1'b1;
      reset_at = 21;
      run_scenario(50);
      for (int k = 0; k < 50; k++) begin
         exp_c = (k < 21) ? spec_ctl(k, 0, 18) : spec_ctl(k, 24, 35);
         n_vec++;
         if (obs_ctl(k) !== exp_c) begin
            n_err++;
            $display("FAIL mid_reset_ctl cycle %0d: got %b expected %b", k, obs_ctl(k), exp_c);
         end
      end
      n_vec++;
      if (r_res[21] !== '0 || r_col[21] !== 2'd0) begin
         n_err++;
         $display("FAIL mid_reset_result: got col %0d data %h expected 0", r_col[21], r_res[21]);
      end
      n_vec++;
      if (r_res[43] !== east[42] || r_col[43] !== 2'd3) begin
         n_err++;
         $display("FAIL mid_reset_rerun_result: got col %0d data %h expected col 3 data %h",
                  r_col[43], r_res[43], east[42]);
      end
      $display("scenario mid reset: reset @21, rerun done @43");
   endtask

   task automatic test_spurious_empty();
      logic [CW-1:0] exp_c;
      clear_stim();
      st[0] = 1'b1;
      emp[2] = 1'b1;
      for (int k = 10; k < MAXC; k++) emp[k] = 1'b1;
      run_scenario(32);
      for (int k = 0; k < 32; k++) begin
         exp_c = spec_ctl(k, 0, 18);
         n_vec++;
         if (obs_ctl(k) !== exp_c) begin
            n_err++;
            $display("FAIL spurious_ctl cycle %0d: got %b expected %b", k, obs_ctl(k), exp_c);
         end
      end
      $display("scenario spurious empty: timing as nominal");
   endtask

   task automatic test_random();
      int ncyc;
      ncyc = 200;
      for (int run = 0; run < 12; run++) begin
         clear_stim();
         for (int k = 0; k < ncyc; k++) begin
            st[k]  = ($urandom_range(0, 3) == 0);
            emp[k] = ($urandom_range(0, 9) == 0);
            acc[k] = ($urandom_range(0, 3) != 0);
         end
         if ((run % 3) == 1) reset_at = $urandom_range(20, 150);
         run_scenario(ncyc);
         build_expected(ncyc);
         for (int k = 0; k < ncyc; k++) begin
            n_vec++;
            if (obs_ctl(k) !== mdl_ctl(k)) begin
               n_err++;
               $display("FAIL random_ctl run %0d cycle %0d: got %b expected %b",
                        run, k, obs_ctl(k), mdl_ctl(k));
            end
            n_vec++;
            if (r_res[k] !== e_res[k]) begin
               n_err++;
               $display("FAIL random_result run %0d cycle %0d: got %h expected %h",
                        run, k, r_res[k], e_res[k]);
            end
            n_vec++;
            if (r_col[k] !== e_col[k]) begin
               n_err++;
               $display("FAIL random_col run %0d cycle %0d: got %0d expected %0d",
                        run, k, r_col[k], e_col[k]);
            end
         end
         $display("random run %0d: %0d cycles, reset_at %0d", run, ncyc, reset_at);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_timeout();
      test_flush_stall();
      test_start_ignored();
      test_mid_reset();
      test_spurious_empty();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
